// File: rtl/wb_tone_pkg.sv
// Shared register map, control-bit positions and tone FSM states for wb_tone.
package wb_tone_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_TARGET = 3'd1;
  localparam logic [2:0] REG_STEP   = 3'd2;
  localparam logic [2:0] REG_CUR    = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;

  localparam int unsigned CTRL_EN    = 0;
  localparam int unsigned CTRL_GLIDE = 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

endpackage

// File: rtl/tone_glide.sv
// Next half-period for a full-period boundary: jump to the target, or glide
// toward it by at most one step without overshooting.
module tone_glide
  import wb_tone_pkg::*;
#(
  parameter int unsigned cnt_w = 24
) (
  input  logic [cnt_w-1:0] cur,
  input  logic [cnt_w-1:0] tgt,
  input  logic [15:0]      step,
  input  logic             glide,
  output logic [cnt_w-1:0] next
);

  logic             up;
  logic [cnt_w-1:0] diff;
  logic [cnt_w-1:0] step_x;
  logic [cnt_w-1:0] move;

  always_comb begin
    up     = tgt > cur;
    diff   = up ? (tgt - cur) : (cur - tgt);
    step_x = cnt_w'(step);
    move   = (step_x < diff) ? step_x : diff;
    if (!glide)  next = tgt;
    else if (up) next = cur + move;
    else         next = cur - move;
  end

endmodule

// File: rtl/wb_tone.sv
// Wishbone slave generating the theremin square wave with optional glide
// between half-periods.
module wb_tone
  import wb_tone_pkg::*;
#(
  parameter int unsigned clk_freq = 100000000,
  parameter int unsigned cnt_w    = 24,
  parameter int unsigned min_half = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_ack_o,
  output logic        audio_o,
  output logic        at_target_o
);

  localparam logic [cnt_w-1:0] one    = cnt_w'(1);
  localparam logic [cnt_w-1:0] min_w  = cnt_w'(min_half);
  localparam int unsigned unused_clk  = clk_freq;

  logic [1:0]       ctrl;
  logic [cnt_w-1:0] target;
  logic [15:0]      step;
  logic [cnt_w-1:0] cur_half;
  logic [cnt_w-1:0] cnt;
  logic [cnt_w-1:0] tgt_eff;
  logic [cnt_w-1:0] next_half;
  state_t           state;

  logic        access;
  logic        write;
  logic        go;
  logic [2:0]  reg_sel;
  logic [31:0] rd_data;
  logic        unused_bits;

  assign unused_bits = ^{wb_sel_i, wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i};

  assign reg_sel     = wb_adr_i[4:2];
  assign access      = wb_stb_i & wb_cyc_i & ~wb_ack_o;
  assign write       = access & wb_we_i;
  assign tgt_eff     = (target == '0) ? '0 : ((target < min_w) ? min_w : target);
  assign go          = ctrl[CTRL_EN] & (tgt_eff != '0);
  assign at_target_o = (cur_half == tgt_eff);

  tone_glide #(.cnt_w(cnt_w)) u_glide (
    .cur   (cur_half),
    .tgt   (tgt_eff),
    .step  (step),
    .glide (ctrl[CTRL_GLIDE]),
    .next  (next_half)
  );

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_CTRL:   rd_data = 32'(ctrl);
      REG_TARGET: rd_data = 32'(target);
      REG_STEP:   rd_data = 32'(step);
      REG_CUR:    rd_data = 32'(cur_half);
      REG_STATUS: rd_data = {30'd0, audio_o, at_target_o};
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      ctrl     <= '0;
      target   <= '0;
      step     <= 16'd1;
    end else begin
      wb_ack_o <= access;
      wb_dat_o <= access ? rd_data : '0;
      if (write) begin
        case (reg_sel)
          REG_CTRL:   ctrl   <= wb_dat_i[1:0];
          REG_TARGET: target <= wb_dat_i[cnt_w-1:0];
          REG_STEP:   step   <= (wb_dat_i[15:0] == '0) ? 16'd1 : wb_dat_i[15:0];
          default:    ;
        endcase
      end
    end
  end

  // Entry starts a high half-period; cur_half only changes on rising toggles,
  // so target/step writes never truncate a half-period in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cur_half <= '0;
      cnt      <= '0;
      audio_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          audio_o <= 1'b0;
          cnt     <= '0;
          if (go) begin
            state    <= RUN;
            cur_half <= tgt_eff;
            cnt      <= tgt_eff - one;
            audio_o  <= 1'b1;
          end
        end
        RUN: begin
          if (!go) begin
            state   <= IDLE;
            audio_o <= 1'b0;
            cnt     <= '0;
          end else if (cnt == '0) begin
            audio_o <= ~audio_o;
            if (!audio_o) begin
              cur_half <= next_half;
              cnt      <= next_half - one;
            end else begin
              cnt <= cur_half - one;
            end
          end else begin
            cnt <= cnt - one;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_tone.sv
// Randomized and directed bench for wb_tone, checked every cycle against a
// toggle-time based behavioural model.
module tb_wb_tone;

  localparam int unsigned CW   = 24;
  localparam longint      MINH = 100;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] adr   = '0;
  logic [31:0] dat_i = '0;
  logic        stb   = 1'b0;
  logic        cyc   = 1'b0;
  logic        we    = 1'b0;
  logic [3:0]  sel   = 4'hF;
  logic [31:0] dat_o;
  logic        ack;
  logic        audio;
  logic        at_tgt;

  wb_tone #(.clk_freq(100000000), .cnt_w(CW), .min_half(100)) dut (
    .clk         (clk),
    .reset       (reset),
    .wb_adr_i    (adr),
    .wb_dat_i    (dat_i),
    .wb_dat_o    (dat_o),
    .wb_stb_i    (stb),
    .wb_cyc_i    (cyc),
    .wb_we_i     (we),
    .wb_sel_i    (sel),
    .wb_ack_o    (ack),
    .audio_o     (audio),
    .at_target_o (at_tgt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [1:0]  m_ctrl;
  logic [23:0] m_target;
  logic [15:0] m_step;
  longint      m_cur, m_toggle, t;
  bit          m_run, m_level, m_ack;
  logic [31:0] m_dat;

  function automatic longint eff(input longint tg);
    if (tg == 0) return 0;
    return (tg < MINH) ? MINH : tg;
  endfunction

  function automatic longint glide_to(input longint c, input longint tg, input longint st);
    if (tg > c) return (c + st > tg) ? tg : c + st;
    return (c - st < tg) ? tg : c - st;
  endfunction

  always @(posedge clk or negedge reset) begin
    longint      te;
    bit          acc;
    logic [31:0] rd;
    logic [2:0]  off;
    if (!reset) begin
      m_ctrl = '0; m_target = '0; m_step = 16'd1; m_cur = 0; m_toggle = 0;
      m_run = 0; m_level = 0; m_ack = 0; m_dat = '0; t = 0;
    end else begin
      t++;
      te  = eff(longint'(m_target));
      off = adr[4:2];
      acc = stb && cyc && !m_ack;
      case (off)
        3'd0:    rd = 32'(m_ctrl);
        3'd1:    rd = 32'(m_target);
        3'd2:    rd = 32'(m_step);
        3'd3:    rd = 32'(m_cur);
        3'd4:    rd = {30'd0, m_level, (m_cur == te)};
        default: rd = '0;
      endcase
      if (!m_run) begin
        if (m_ctrl[0] && te != 0) begin
          m_run = 1; m_level = 1; m_cur = te; m_toggle = t + te;
        end
      end else if (!(m_ctrl[0] && te != 0)) begin
        m_run = 0; m_level = 0;
      end else if (t == m_toggle) begin
        m_level = !m_level;
        if (m_level) m_cur = m_ctrl[1] ? glide_to(m_cur, te, longint'(m_step)) : te;
        m_toggle = t + m_cur;
      end
      if (acc && we) begin
        case (off)
          3'd0: m_ctrl   = dat_i[1:0];
          3'd1: m_target = dat_i[23:0];
          3'd2: m_step   = (dat_i[15:0] == '0) ? 16'd1 : dat_i[15:0];
          default: ;
        endcase
      end
      m_dat = acc ? rd : '0;
      m_ack = acc;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("ack",       64'(ack),    64'(m_ack));
      check("dat",       64'(dat_o),  64'(m_dat));
      check("audio",     64'(audio),  64'(m_level));
      check("at_target", 64'(at_tgt), 64'(m_cur == eff(longint'(m_target))));
    end
  end

  // ---------------- bus helpers ----------------
  task automatic wb_xfer(input bit w, input int unsigned off, input logic [31:0] d,
                         output logic [31:0] q);
    int unsigned n;
    @(negedge clk);
    adr = off << 2; dat_i = d; we = w; stb = 1'b1; cyc = 1'b1; n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 4);
    check("wb_ack_seen", 64'(ack), 64'(1));
    q = dat_o;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input int unsigned off, input logic [31:0] d);
    logic [31:0] q;
    wb_xfer(1'b1, off, d, q);
  endtask

  task automatic wb_read(input int unsigned off, output logic [31:0] q);
    wb_xfer(1'b0, off, '0, q);
  endtask

  task automatic wait_level(input logic lvl, input int unsigned lim, output int unsigned n);
    n = 0;
    while (audio !== lvl && n < lim) begin
      @(negedge clk);
      n++;
    end
    check("audio_edge_in_time", 64'(audio), 64'(lvl));
  endtask

  task automatic wait_rise(input int unsigned lim);
    int unsigned n;
    wait_level(1'b0, lim, n);
    wait_level(1'b1, lim, n);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q;
    int unsigned n;
    longint glide_exp [4] = '{1100, 1200, 1300, 1350};

    #2 reset = 1'b0;
    #1 chk_on = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // reset values
    wb_read(0, q); check("rst_ctrl",   64'(q), 64'(0));
    wb_read(1, q); check("rst_target", 64'(q), 64'(0));
    wb_read(2, q); check("rst_step",   64'(q), 64'(1));
    wb_read(3, q); check("rst_cur",    64'(q), 64'(0));
    wb_read(4, q); check("rst_status", 64'(q), 64'(1));
    wb_read(6, q); check("rst_reg6",   64'(q), 64'(0));

    // plain tone, target 1000
    wb_write(1, 1000);
    wb_write(0, 1);
    wait_level(1'b1, 5, n);    check("first_high_delay", 64'(n), 64'(1));
    wait_level(1'b0, 1500, n); check("high_half_1000",   64'(n), 64'(1000));
    wait_level(1'b1, 1500, n); check("low_half_1000",    64'(n), 64'(1000));
    check("at_target_1000", 64'(at_tgt), 64'(1));

    // target below minimum
    wb_write(1, 50);
    wait_rise(1200);
    wb_read(3, q); check("cur_clamped", 64'(q), 64'(100));
    wait_level(1'b0, 200, n);
    wait_level(1'b1, 200, n);  check("low_half_100", 64'(n), 64'(100));

    // target write in the middle of a half-period
    wb_write(1, 1000);
    wait_rise(300);
    repeat (600) @(negedge clk);
    wb_write(1, 300);
    wait_level(1'b0, 1000, n);
    wait_level(1'b1, 1100, n); check("old_low_kept", 64'(n), 64'(1000));
    wait_level(1'b0, 400, n);  check("new_high_300", 64'(n), 64'(300));

    // glide 1000 -> 1350 in steps of 100
    wb_write(1, 1000);
    wait_level(1'b1, 400, n);
    wb_write(2, 100);
    wb_write(0, 3);
    wb_write(1, 1350);
    for (int i = 0; i < 4; i++) begin
      wait_rise(1500);
      wb_read(3, q); check("glide_cur", 64'(q), 64'(glide_exp[i]));
      wb_read(4, q); check("glide_at_target", 64'(q[0]), 64'(i == 3));
    end
    wait_rise(1500);
    wb_read(3, q); check("glide_no_overshoot", 64'(q), 64'(1350));

    // EN off, then restart
    wb_write(0, 2);
    @(negedge clk); check("en_off_audio_low", 64'(audio), 64'(0));
    repeat (50) @(negedge clk);
    check("en_off_stays_low", 64'(audio), 64'(0));
    wb_write(0, 1);
    wait_level(1'b1, 5, n);    check("restart_delay", 64'(n), 64'(1));
    wait_level(1'b0, 1500, n); check("restart_high_full", 64'(n), 64'(1350));

    // maximum target
    wb_write(1, 32'h00FF_FFFF);
    wait_level(1'b1, 1500, n);
    wb_read(3, q); check("max_cur",    64'(q), 64'h00FF_FFFF);
    wb_read(4, q); check("max_status", 64'(q), 64'(3));
    repeat (200) @(negedge clk);
    wb_write(0, 0);

    // held strobe acks every other cycle
    @(negedge clk);
    adr = 32'h10; we = 1'b0; stb = 1'b1; cyc = 1'b1; n = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack) n++;
    end
    stb = 1'b0; cyc = 1'b0;
    check("held_strobe_acks", 64'(n), 64'(3));

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0: repeat ($urandom_range(1, 300)) @(negedge clk);
        1: wb_write(1, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 99) : $urandom_range(100, 500));
        2: wb_write(0, $urandom);
        3: wb_write(2, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 400));
        4: wb_read($urandom_range(0, 7), q);
        default: wb_write($urandom_range(3, 7), $urandom);
      endcase
    end

    // asynchronous reset mid-period with an ack in flight
    wb_write(1, 200);
    wb_write(0, 1);
    wait_level(1'b1, 5, n);
    repeat (20) @(negedge clk);
    adr = 32'h0; we = 1'b0; stb = 1'b1; cyc = 1'b1;
    @(posedge clk);
    #3;
    check("ack_before_reset", 64'(ack), 64'(1));
    reset = 1'b0;
    #1;
    check("reset_audio_drop", 64'(audio), 64'(0));
    check("reset_ack_drop",   64'(ack),   64'(0));
    check("reset_dat_clear",  64'(dat_o), 64'(0));
    @(negedge clk);
    stb = 1'b0; cyc = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wb_read(0, q); check("post_rst_ctrl",   64'(q), 64'(0));
    wb_read(1, q); check("post_rst_target", 64'(q), 64'(0));
    wb_read(2, q); check("post_rst_step",   64'(q), 64'(1));
    wb_read(3, q); check("post_rst_cur",    64'(q), 64'(0));
    wb_read(4, q); check("post_rst_status", 64'(q), 64'(1));

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
